// File: rtl/adc_avg_sequencer.sv
// adc_avg_sequencer: fires 2^AVG_LOG2 SAR conversions per start request,
// accumulates the results and presents one averaged code on valid/ready.
// The self-timed ADC done flag is synchronised into clk before use.
//
// Build option: define ADC_AVG_ROUND_EN for round-half-up averaging;
// without it the average is truncated.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; busy low
// S_FIRE | one-cycle st_conv pulse, timer reloaded
// S_WAIT | timer running, waiting for a done rising edge
// S_OUT  | averaged code presented until avg_ready handshake
module adc_avg_sequencer #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              st_conv,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [AVG_LOG2:0] sample_cnt,
  output logic              timeout_err
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] N_SAMPLES = (AVG_LOG2 + 1)'(1 << AVG_LOG2);
  // Down-counter load value: terminal count 0 is reached after TIMEOUT WAIT cycles.
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              done_s1;
  logic              done_s2;
  logic              done_s3;
  logic              done_rise;
  logic [15:0]       timer;
  logic              timer_tc;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              last_sample;
  logic [DATA_W-1:0] avg_next;

  assign done_rise   = done_s2 & ~done_s3;
  assign timer_tc    = (timer == '0);
  assign acc_sum     = acc + ACC_W'(result);
  assign last_sample = ((sample_cnt + 1'b1) == N_SAMPLES);
  assign busy        = (state != S_IDLE);
  assign avg_valid   = (state == S_OUT);

`ifdef ADC_AVG_ROUND_EN
  localparam logic [ACC_W:0] ROUND_ADD = (ACC_W + 1)'((1 << AVG_LOG2) >> 1);
  logic [ACC_W:0] rounded;
  logic           unused_round;
  // Extra headroom bit keeps the rounding add exact; it is never set in practice.
  assign rounded      = {1'b0, acc_sum} + ROUND_ADD;
  assign avg_next     = rounded[AVG_LOG2 +: DATA_W];
  assign unused_round = ^rounded;
`else
  assign avg_next = acc_sum[AVG_LOG2 +: DATA_W];
`endif

  // Two-flop synchroniser plus one edge-detect flop on the ADC done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_s3 <= 1'b0;
    end else begin
      done_s1 <= adc_done;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; a done edge takes priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_FIRE;
      S_FIRE: state_next = S_WAIT;
      S_WAIT: begin
        if (done_rise) state_next = last_sample ? S_OUT : S_FIRE;
        else if (timer_tc) state_next = S_IDLE;
      end
      S_OUT: if (avg_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered conversion strobe, high for the single FIRE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_conv <= 1'b0;
    else     st_conv <= (state_next == S_FIRE);
  end

  // Timer, accumulator, sample count, average and timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      acc         <= '0;
      sample_cnt  <= '0;
      avg_out     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc         <= '0;
            sample_cnt  <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_FIRE: timer <= TIMER_LOAD;
        S_WAIT: begin
          if (done_rise) begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + 1'b1;
            if (last_sample) avg_out <= avg_next;
          end else if (timer_tc) begin
            timeout_err <= 1'b1;
            acc         <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Bench for adc_avg_sequencer: drives an emulated SAR ADC by hand and
// compares each burst's average against a plain-arithmetic reference.
module tb_adc_avg_sequencer;

  localparam int DW    = 12;
  localparam int AL    = 2;
  localparam int TO    = 255;
  localparam int N_AVG = 1 << AL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          st_conv;
  logic          adc_done = 1'b0;
  logic [DW-1:0] result = '0;
  logic [DW-1:0] avg_out;
  logic          avg_valid;
  logic          avg_ready = 1'b0;
  logic [AL:0]   sample_cnt;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [DW-1:0] burst_vals [N_AVG];

  adc_avg_sequencer #(.DATA_W(DW), .AVG_LOG2(AL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .st_conv(st_conv),
    .adc_done(adc_done), .result(result), .avg_out(avg_out),
    .avg_valid(avg_valid), .avg_ready(avg_ready), .sample_cnt(sample_cnt),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  // Count st_conv pulses (high for exactly one cycle each).
  initial forever begin
    @(negedge clk);
    if (st_conv) pulse_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] ref_avg(input int unsigned sum);
`ifdef ADC_AVG_ROUND_EN
    return DW'((sum + N_AVG / 2) / N_AVG);
`else
    return DW'(sum / N_AVG);
`endif
  endfunction

  function automatic int unsigned burst_sum();
    int unsigned s = 0;
    for (int i = 0; i < N_AVG; i++) s += burst_vals[i];
    return s;
  endfunction

  task automatic randomize_vals();
    for (int i = 0; i < N_AVG; i++) burst_vals[i] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; adc_done = 1'b0; avg_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Emulated ADC: random conversion time, done must be low before it rises.
  task automatic adc_convert(input logic [DW-1:0] v, input bit keep_high);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    if (adc_done) begin
      adc_done = 1'b0;
      @(negedge clk);
    end
    result = v;
    adc_done = 1'b1;
    repeat (2) @(negedge clk);
    if (!keep_high) adc_done = 1'b0;
  endtask

  task automatic wait_st_conv(output bit ok);
    int n = 0;
    while (!st_conv && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = st_conv;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_st_conv: no st_conv within %0d cycles", n);
    end
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!avg_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = avg_valid;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_valid: no avg_valid within %0d cycles", n);
    end
  endtask

  task automatic drive_conversions(input bit skip_first_wait, input bit keep_last_high, output bit ok);
    bit w;
    ok = 1'b0;
    for (int i = 0; i < N_AVG; i++) begin
      if (!(skip_first_wait && i == 0)) begin
        wait_st_conv(w);
        if (!w) return;
      end
      adc_convert(burst_vals[i], keep_last_high && (i == N_AVG - 1));
    end
    wait_valid(ok);
  endtask

  task automatic run_burst(input bit keep_last_high, output bit ok);
    pulse_cnt = 0;
    pulse_start();
    drive_conversions(1'b0, keep_last_high, ok);
  endtask

  task automatic check_burst(input string name);
    logic [DW-1:0] exp = ref_avg(burst_sum());
    checks++;
    if (avg_out !== exp) begin
      errors++;
      $display("FAIL %s avg_out: got %0d expected %0d", name, avg_out, exp);
    end
    checks++;
    if (sample_cnt !== (AL + 1)'(N_AVG)) begin
      errors++;
      $display("FAIL %s sample_cnt: got %0d expected %0d", name, sample_cnt, N_AVG);
    end
    checks++;
    if (pulse_cnt != N_AVG) begin
      errors++;
      $display("FAIL %s st_conv_pulses: got %0d expected %0d", name, pulse_cnt, N_AVG);
    end
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
    checks++;
    if ({busy, avg_valid} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_handshake busy,valid: got %b expected 00", name, {busy, avg_valid});
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, st_conv, avg_valid, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl busy,st_conv,valid,terr: got %b expected 0000",
               {busy, st_conv, avg_valid, timeout_err});
    end
    checks++;
    if (avg_out !== '0 || sample_cnt !== '0) begin
      errors++;
      $display("FAIL reset_data avg_out=%0d sample_cnt=%0d expected 0 0", avg_out, sample_cnt);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if ({busy, st_conv} !== 2'b11) begin
      errors++;
      $display("FAIL start_latency busy,st_conv: got %b expected 11", {busy, st_conv});
    end
    @(negedge clk);
    checks++;
    if ({busy, st_conv} !== 2'b10) begin
      errors++;
      $display("FAIL st_conv_width busy,st_conv: got %b expected 10", {busy, st_conv});
    end
    apply_reset();
  endtask

  task automatic test_known();
    bit ok;
    for (int i = 0; i < N_AVG; i++) burst_vals[i] = DW'(100 + i);
    run_burst(1'b0, ok);
    if (ok) check_burst("known");
  endtask

  task automatic test_full_scale();
    bit ok;
    for (int i = 0; i < N_AVG; i++) burst_vals[i] = '1;
    run_burst(1'b0, ok);
    if (ok) check_burst("full_scale");
  endtask

  task automatic test_random();
    bit ok;
    for (int b = 0; b < 6; b++) begin
      randomize_vals();
      run_burst(1'b0, ok);
      if (ok) check_burst("random");
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DW-1:0] exp;
    randomize_vals();
    exp = ref_avg(burst_sum());
    run_burst(1'b0, ok);
    if (!ok) return;
    pulse_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c % 3 == 0);
      @(negedge clk);
      checks++;
      if (avg_valid !== 1'b1 || busy !== 1'b1 || avg_out !== exp) begin
        errors++;
        $display("FAIL backpressure_hold c=%0d valid=%b busy=%b avg_out=%0d expected 1 1 %0d",
                 c, avg_valid, busy, avg_out, exp);
      end
    end
    start = 1'b0;
    checks++;
    if (pulse_cnt != 0) begin
      errors++;
      $display("FAIL backpressure_start_ignored st_conv_pulses: got %0d expected 0", pulse_cnt);
    end
    pulse_cnt = N_AVG;
    check_burst("backpressure");
  endtask

  task automatic test_timeout();
    bit ok;
    bit saw_valid = 1'b0;
    int n = 0;
    randomize_vals();
    pulse_cnt = 0;
    pulse_start();
    wait_st_conv(ok);
    if (!ok) return;
    adc_convert(burst_vals[0], 1'b0);
    wait_st_conv(ok);
    if (!ok) return;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      if (avg_valid) saw_valid = 1'b1;
    end
    checks++;
    if (n != TO + 1) begin
      errors++;
      $display("FAIL timeout_cycles busy_after_fire: got %0d expected %0d", n, TO + 1);
    end
    checks++;
    if (timeout_err !== 1'b1 || saw_valid) begin
      errors++;
      $display("FAIL timeout_flag timeout_err=%b saw_valid=%b expected 1 0", timeout_err, saw_valid);
    end
    checks++;
    if (pulse_cnt != 2) begin
      errors++;
      $display("FAIL timeout_pulses st_conv_pulses: got %0d expected 2", pulse_cnt);
    end
    randomize_vals();
    pulse_cnt = 0;
    pulse_start();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear timeout_err: got %b expected 0", timeout_err);
    end
    drive_conversions(1'b0, 1'b0, ok);
    if (ok) check_burst("after_timeout");
  endtask

  task automatic test_reset_mid();
    bit ok;
    randomize_vals();
    pulse_cnt = 0;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      wait_st_conv(ok);
      if (!ok) return;
      adc_convert(burst_vals[i], 1'b0);
    end
    wait_st_conv(ok);
    if (!ok) return;
    rst = 1'b1;
    #1;
    checks++;
    if ({st_conv, busy, avg_valid, timeout_err} !== 4'b0000 || sample_cnt !== '0 || avg_out !== '0) begin
      errors++;
      $display("FAIL reset_mid st_conv,busy,valid,terr=%b sample_cnt=%0d avg_out=%0d expected 0000 0 0",
               {st_conv, busy, avg_valid, timeout_err}, sample_cnt, avg_out);
    end
    @(negedge clk);
    rst = 1'b0;
    randomize_vals();
    run_burst(1'b0, ok);
    if (ok) check_burst("after_reset_mid");
  endtask

  task automatic test_stale_done();
    bit ok;
    randomize_vals();
    run_burst(1'b1, ok);
    if (!ok) return;
    check_burst("stale_setup");
    randomize_vals();
    pulse_cnt = 0;
    pulse_start();
    repeat (12) @(negedge clk);
    checks++;
    if (sample_cnt !== '0 || busy !== 1'b1 || pulse_cnt != 1) begin
      errors++;
      $display("FAIL stale_done sample_cnt=%0d busy=%b pulses=%0d expected 0 1 1",
               sample_cnt, busy, pulse_cnt);
    end
    drive_conversions(1'b1, 1'b0, ok);
    if (ok) check_burst("stale_done");
  endtask

  initial begin
    test_reset();
    test_known();
    test_full_scale();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_stale_done();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
